// File: rtl/fetch_align_queue.sv
// Halfword-granular fetch alignment queue: takes 8-byte fetch packets, presents a
// 4-halfword decode window from the head, and sequences redirects (flush/retarget).
module fetch_align_queue #(
    parameter logic [31:0] RESET_VECTOR = 32'h80000000,
    parameter int          DEPTH        = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_valid,
    input  logic [31:0] i_fetch_pc,
    input  logic [63:0] i_fetch_data,
    output logic        o_fetch_ready,
    output logic [63:0] o_win_data,
    output logic [3:0]  o_win_valid,
    output logic [31:0] o_win_pc,
    input  logic [2:0]  i_consume,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] head_reg, tail_reg;
    logic [PW:0]   count_reg;
    logic [31:0]   win_pc_reg, expect_pc_reg;
    logic [15:0]   mem [DEPTH];

    logic          accept, line_hit, write_en;
    logic [1:0]    first;
    logic [2:0]    n_wr, avail, cons_c;
    logic [PW:0]   count_next;
    logic [PW-1:0] wr_idx [4];
    logic [15:0]   wr_data [4];
    logic [3:0]    wr_lane_en;

    // Pointer low bits of the fetch PC and bit 0 of expect_pc carry no information.
    logic unused_bits;
    assign unused_bits = ^{i_fetch_pc[2:0], expect_pc_reg[0]};

    // Ready is based on registered occupancy only; consumes give no same-cycle credit.
    assign o_fetch_ready = (count_reg <= (PW+1)'(DEPTH - 4));

    always_comb begin
        accept     = i_fetch_valid & o_fetch_ready & ~i_flush;
        line_hit   = (i_fetch_pc[31:3] == expect_pc_reg[31:3]);
        write_en   = accept & line_hit;
        first      = expect_pc_reg[2:1];
        n_wr       = write_en ? (3'd4 - {1'b0, first}) : 3'd0;
        avail      = (count_reg >= (PW+1)'(4)) ? 3'd4 : count_reg[2:0];
        cons_c     = (i_consume > avail) ? avail : i_consume;
        count_next = count_reg - (PW+1)'(cons_c) + (PW+1)'(n_wr);
    end

    // Write lanes: lane gi stores packet halfword (first+gi) at tail+gi.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wr_lane
            logic [1:0] src;
            assign src            = first + 2'(gi);
            assign wr_idx[gi]     = tail_reg + PW'(gi);
            assign wr_data[gi]    = i_fetch_data[16*src +: 16];
            assign wr_lane_en[gi] = (3'(gi) < n_wr);
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        for (int j = 0; j < 4; j++) begin
            if (wr_lane_en[j]) begin
                mem[wr_idx[j]] <= wr_data[j];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            win_pc_reg    <= RESET_VECTOR;
            expect_pc_reg <= RESET_VECTOR;
        end else if (i_flush) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            win_pc_reg    <= i_flush_pc;
            expect_pc_reg <= i_flush_pc;
        end else begin
            head_reg   <= head_reg + PW'(cons_c);
            tail_reg   <= tail_reg + PW'(n_wr);
            count_reg  <= count_next;
            win_pc_reg <= win_pc_reg + {28'd0, cons_c, 1'b0};
            if (write_en) begin
                expect_pc_reg <= {expect_pc_reg[31:3] + 29'd1, 3'b000};
            end
        end
    end

    // Window read mux straight off the storage registers; wraps mod DEPTH.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_win
            assign o_win_data[16*gi +: 16] = mem[head_reg + PW'(gi)];
            assign o_win_valid[gi]         = (count_reg > (PW+1)'(gi));
        end
    endgenerate

    assign o_win_pc = win_pc_reg;

endmodule
